aq_clint_kid: RTL

Per-hart core-local interrupt source. It sits between the APB system bus and the sysio kid, and generates the machine and supervisor software and timer interrupt levels that the sysio kid samples. It holds the MSIP/SSIP bits and the 64-bit MTIMECMP/STIMECMP registers. It compares both compare registers against the free-running system time and drives `clint_core_*_int`. All state is clocked on `forever_cpuclk` and qualified by `apb_clk_en`.

---
 rtl/aq_clint_kid.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/aq_clint_kid.sv
// Per-hart core-local interrupt source: MSIP/SSIP bits and 64-bit MTIMECMP/STIMECMP
// behind a zero-wait-state APB slave, producing registered software and timer interrupt levels.

module gated_clk_cell (
    input  logic clk_in,
    input  logic global_en,
    input  logic module_en,
    input  logic local_en,
    input  logic external_en,
    input  logic pad_yy_icg_scan_en,
    output logic clk_out
);
    // FPGA build: the clock passes straight through.
    // The flops it drives qualify every update with the enable themselves.
    logic unused_gate_en;

    assign unused_gate_en = (global_en & (module_en | local_en)) | external_en | pad_yy_icg_scan_en;
    assign clk_out        = clk_in;
endmodule

module aq_clint_kid (
    input  logic        forever_cpuclk,
    input  logic        cpurst_b,
    input  logic        apb_clk_en,
    input  logic        pad_yy_icg_scan_en,
    input  logic [63:0] sysio_clint_mtime,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [15:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic        clint_core_ms_int,
    output logic        clint_core_ss_int,
    output logic        clint_core_mt_int,
    output logic        clint_core_st_int
);
    localparam int NREG      = 6;
    localparam int IDX_MSIP  = 0;
    localparam int IDX_MTCL  = 1;
    localparam int IDX_MTCH  = 2;
    localparam int IDX_SSIP  = 3;
    localparam int IDX_STCL  = 4;
    localparam int IDX_STCH  = 5;

    // Word offsets (byte address >> 2) of the mapped registers, indexed by IDX_*.
    localparam logic [13:0] REG_WOFF [NREG] = '{
        14'h0000, 14'h1000, 14'h1001, 14'h3000, 14'h3400, 14'h3401
    };

    logic        clint_clk;
    logic [1:0]  unused_paddr_lsb;

    logic [NREG-1:0] hit;
    logic            mapped;
    logic            setup_en;
    logic            wr_en;
    logic [31:0]     rdata_mux;

    logic        msip_q, msip_d;
    logic        ssip_q, ssip_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [63:0] stimecmp_q, stimecmp_d;
    logic [31:0] prdata_q, prdata_d;
    logic        ms_int_q, ms_int_d;
    logic        ss_int_q, ss_int_d;
    logic        mt_int_q, mt_int_d;
    logic        st_int_q, st_int_d;

    gated_clk_cell x_clint_gated_clk (
        .clk_in             (forever_cpuclk),
        .global_en          (1'b1),
        .module_en          (1'b0),
        .local_en           (apb_clk_en),
        .external_en        (1'b0),
        .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
        .clk_out            (clint_clk)
    );

    assign unused_paddr_lsb = paddr[1:0];

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_dec
            assign hit[gi] = (paddr[15:2] == REG_WOFF[gi]);
        end
    endgenerate

    assign mapped   = |hit;
    assign setup_en = apb_clk_en & psel & ~penable;
    assign wr_en    = apb_clk_en & psel & penable & pwrite;

    assign pready   = psel & penable;
    assign pslverr  = psel & penable & ~mapped;

    // Decode is one-hot, so at most one of these overrides the zero default.
    always_comb begin
        rdata_mux = '0;
        if (hit[IDX_MSIP]) rdata_mux = {31'd0, msip_q};
        if (hit[IDX_MTCL]) rdata_mux = mtimecmp_q[31:0];
        if (hit[IDX_MTCH]) rdata_mux = mtimecmp_q[63:32];
        if (hit[IDX_SSIP]) rdata_mux = {31'd0, ssip_q};
        if (hit[IDX_STCL]) rdata_mux = stimecmp_q[31:0];
        if (hit[IDX_STCH]) rdata_mux = stimecmp_q[63:32];
    end

    always_comb begin
        msip_d     = msip_q;
        ssip_d     = ssip_q;
        mtimecmp_d = mtimecmp_q;
        stimecmp_d = stimecmp_q;
        if (wr_en) begin
            if (hit[IDX_MSIP]) msip_d             = pwdata[0];
            if (hit[IDX_MTCL]) mtimecmp_d[31:0]   = pwdata;
            if (hit[IDX_MTCH]) mtimecmp_d[63:32]  = pwdata;
            if (hit[IDX_SSIP]) ssip_d             = pwdata[0];
            if (hit[IDX_STCL]) stimecmp_d[31:0]   = pwdata;
            if (hit[IDX_STCH]) stimecmp_d[63:32]  = pwdata;
        end
    end

    // Interrupts sample the pre-write register values, so a write shows up one enabled edge later.
    always_comb begin
        prdata_d = prdata_q;
        ms_int_d = ms_int_q;
        ss_int_d = ss_int_q;
        mt_int_d = mt_int_q;
        st_int_d = st_int_q;
        if (setup_en) begin
            prdata_d = rdata_mux;
        end
        if (apb_clk_en) begin
            ms_int_d = msip_q;
            ss_int_d = ssip_q;
            mt_int_d = (sysio_clint_mtime >= mtimecmp_q);
            st_int_d = (sysio_clint_mtime >= stimecmp_q);
        end
    end

    always_ff @(posedge clint_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            msip_q     <= 1'b0;
            ssip_q     <= 1'b0;
            mtimecmp_q <= '1;
            stimecmp_q <= '1;
            prdata_q   <= '0;
            ms_int_q   <= 1'b0;
            ss_int_q   <= 1'b0;
            mt_int_q   <= 1'b0;
            st_int_q   <= 1'b0;
        end else begin
            msip_q     <= msip_d;
            ssip_q     <= ssip_d;
            mtimecmp_q <= mtimecmp_d;
            stimecmp_q <= stimecmp_d;
            prdata_q   <= prdata_d;
            ms_int_q   <= ms_int_d;
            ss_int_q   <= ss_int_d;
            mt_int_q   <= mt_int_d;
            st_int_q   <= st_int_d;
        end
    end

    assign prdata            = prdata_q;
    assign clint_core_ms_int = ms_int_q;
    assign clint_core_ss_int = ss_int_q;
    assign clint_core_mt_int = mt_int_q;
    assign clint_core_st_int = st_int_q;
endmodule
